// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU decode/execute behind valid/ready with a one-deep output register; define ALU_MUL_EN for the iterative MUL
module alu_exec_unit #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [9:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       alu_ctrl
);
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100, ALU_SRL = 4'b0101, ALU_SUB = 4'b0110, ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000, ALU_SLTU = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] ALU_MUL = 4'b1010;
`endif
  logic [3:0] ctrl_d, fin_ctrl;
  logic ill_d, fin_ill, take, is_mul, ld_mul, busy, load;
  logic [WIDTH-1:0] res_d, fin_res, result_q;
  logic [SHW-1:0] shamt;
  logic out_valid_q, zero_q, illegal_q;
  logic [3:0] alu_ctrl_q;
  assign shamt = b[SHW-1:0];
  always_comb begin
    ctrl_d = ALU_AND;
    ill_d = 1'b0;
    case (alu_op)
      2'b00: ctrl_d = ALU_ADD;
      2'b01: ctrl_d = ALU_SUB;
      2'b10:
        case (funct)
          10'b0000000_000: ctrl_d = ALU_ADD;
          10'b0100000_000: ctrl_d = ALU_SUB;
          10'b0000000_001: ctrl_d = ALU_SLL;
          10'b0000000_010: ctrl_d = ALU_SLT;
          10'b0000000_011: ctrl_d = ALU_SLTU;
          10'b0000000_100: ctrl_d = ALU_XOR;
          10'b0000000_101: ctrl_d = ALU_SRL;
          10'b0100000_101: ctrl_d = ALU_SRA;
          10'b0000000_110: ctrl_d = ALU_OR;
          10'b0000000_111: ctrl_d = ALU_AND;
`ifdef ALU_MUL_EN
          10'b0000001_000: ctrl_d = ALU_MUL;
`endif
          default: ill_d = 1'b1;
        endcase
      default:
        case (funct[2:0])
          3'b000: ctrl_d = ALU_ADD;
          3'b001: {ill_d, ctrl_d} = funct[9:3] == 7'b0000000 ? {1'b0, ALU_SLL} : {1'b1, ALU_AND};
          3'b010: ctrl_d = ALU_SLT;
          3'b011: ctrl_d = ALU_SLTU;
          3'b100: ctrl_d = ALU_XOR;
          3'b101: {ill_d, ctrl_d} = funct[9:3] == 7'b0000000 ? {1'b0, ALU_SRL} :
                                    funct[9:3] == 7'b0100000 ? {1'b0, ALU_SRA} : {1'b1, ALU_AND};
          3'b110: ctrl_d = ALU_OR;
          default: ctrl_d = ALU_AND;
        endcase
    endcase
  end
  always_comb begin
    res_d = '0;
    case (ctrl_d)
      ALU_AND: res_d = a & b;
      ALU_OR: res_d = a | b;
      ALU_ADD: res_d = a + b;
      ALU_SUB: res_d = a - b;
      ALU_XOR: res_d = a ^ b;
      ALU_SLL: res_d = a << shamt;
      ALU_SRL: res_d = a >> shamt;
      ALU_SRA: res_d = WIDTH'($signed(a) >>> shamt);
      ALU_SLT: res_d = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: res_d = WIDTH'(a < b);
      default: res_d = '0;
    endcase
    if (ill_d) res_d = '0;
  end
`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [SHW:0] cnt_q;
  assign busy = state_q == MUL_BUSY;
  assign is_mul = ctrl_d == ALU_MUL;
  assign ld_mul = busy && cnt_q == (SHW+1)'(WIDTH);
  assign fin_res = ld_mul ? acc_q : res_d;
  assign fin_ctrl = ld_mul ? ALU_MUL : ctrl_d;
  assign fin_ill = !ld_mul && ill_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
    end else if (take && is_mul) begin
      state_q <= MUL_BUSY;
      acc_q <= '0;
      mcand_q <= a;
      mplier_q <= b;
      cnt_q <= '0;
    end else if (busy) begin
      state_q <= ld_mul ? IDLE : MUL_BUSY;
      acc_q <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign busy = 1'b0;
  assign is_mul = 1'b0;
  assign ld_mul = 1'b0;
  assign fin_res = res_d;
  assign fin_ctrl = ctrl_d;
  assign fin_ill = ill_d;
`endif
  assign in_ready = !busy && (!out_valid_q || out_ready);
  assign take = in_valid && in_ready;
  assign load = (take && !is_mul) || ld_mul;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      illegal_q <= 1'b0;
      alu_ctrl_q <= 4'b0000;
    end else if (load) begin
      out_valid_q <= 1'b1;
      result_q <= fin_res;
      zero_q <= fin_res == '0;
      illegal_q <= fin_ill;
      alu_ctrl_q <= fin_ctrl;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign zero = zero_q;
  assign illegal = illegal_q;
  assign alu_ctrl = alu_ctrl_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model
module tb_alu_exec_unit;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [9:0] funct = '0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, zero, illegal;
  logic [W-1:0] result;
  logic [3:0] alu_ctrl;
  int passed = 0, total = 0;
  logic [9:0] fs [10] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h005, 10'h105, 10'h002, 10'h003};
  logic [7:0] rs [10] = '{8'h88, 8'h82, 8'h01, 8'h87, 8'h86, 8'h28, 8'h10, 8'hF0, 8'h01, 8'h00};
  logic [3:0] cs [10] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9};
  logic [9:0] legal [11] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h005, 10'h105, 10'h002, 10'h003, 10'h008};
  logic [14:0] got, exp;
  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .alu_ctrl(alu_ctrl)
  );
  always #5 clk = ~clk;
  assign got = {out_valid, illegal, alu_ctrl, result, zero};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [9:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    alu_op = op;
    funct = f;
    a = x;
    b = y;
  endtask
  task automatic model(input logic [1:0] op, input logic [9:0] f, input logic [7:0] x, input logic [7:0] y,
                       output logic mi, output logic [3:0] mc, output logic [7:0] mr);
    string m;
    int sx, sy, sh;
    m = "ill";
    if (op == 2'b00) m = "add";
    else if (op == 2'b01) m = "sub";
    else if (op == 2'b10) begin
      case (f)
        10'h000: m = "add";
        10'h100: m = "sub";
        10'h001: m = "sll";
        10'h002: m = "slt";
        10'h003: m = "sltu";
        10'h004: m = "xor";
        10'h005: m = "srl";
        10'h105: m = "sra";
        10'h006: m = "or";
        10'h007: m = "and";
`ifdef ALU_MUL_EN
        10'h008: m = "mul";
`endif
        default: m = "ill";
      endcase
    end else begin
      case (f[2:0])
        3'd0: m = "add";
        3'd1: m = f[9:3] == 7'h00 ? "sll" : "ill";
        3'd2: m = "slt";
        3'd3: m = "sltu";
        3'd4: m = "xor";
        3'd5: m = f[9:3] == 7'h00 ? "srl" : f[9:3] == 7'h20 ? "sra" : "ill";
        3'd6: m = "or";
        default: m = "and";
      endcase
    end
    sx = x >= 8'd128 ? int'(x) - 256 : int'(x);
    sy = y >= 8'd128 ? int'(y) - 256 : int'(y);
    sh = int'(y) % W;
    mi = 1'b0;
    case (m)
      "add": begin mc = 4'h2; mr = 8'((int'(x) + int'(y)) & 255); end
      "sub": begin mc = 4'h6; mr = 8'((int'(x) - int'(y)) & 255); end
      "and": begin mc = 4'h0; mr = x & y; end
      "or": begin mc = 4'h1; mr = x | y; end
      "xor": begin mc = 4'h3; mr = x ^ y; end
      "sll": begin mc = 4'h4; mr = 8'((int'(x) * (1 << sh)) & 255); end
      "srl": begin mc = 4'h5; mr = 8'(int'(x) / (1 << sh)); end
      "sra": begin mc = 4'h7; mr = 8'((sx >>> sh) & 255); end
      "slt": begin mc = 4'h8; mr = sx < sy ? 8'd1 : 8'd0; end
      "sltu": begin mc = 4'h9; mr = int'(x) < int'(y) ? 8'd1 : 8'd0; end
      "mul": begin mc = 4'hA; mr = 8'((int'(x) * int'(y)) & 255); end
      default: begin mi = 1'b1; mc = 4'h0; mr = 8'h00; end
    endcase
  endtask
  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
    tick;
    rst = 1'b0;
    exp = {1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    total++; if (got !== exp || in_ready !== 1'b1) $display("FAIL reset_init got %h rdy %b exp %h rdy 1", got, in_ready, exp); else passed++;
    drive(1, 2'b10, 10'h008, 8'h0D, 8'h0B);
    tick;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    total++; if (got !== exp || in_ready !== 1'b1) $display("FAIL reset_mid_mul got %h rdy %b exp %h rdy 1", got, in_ready, exp); else passed++;
    repeat (12) tick;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_abort out_valid got %b exp 0", out_valid); else passed++;
  endtask
  task automatic test_rtype_sweep;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 2'b10, fs[i], 8'h85, 8'h03);
      tick;
      exp = {1'b1, 1'b0, cs[i], rs[i], rs[i] == 8'h00};
      total++; if (got !== exp || in_ready !== 1'b1) $display("FAIL sweep[%0d] got %h rdy %b exp %h rdy 1", i, got, in_ready, exp); else passed++;
    end
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
  endtask
  task automatic test_branch_illegal;
    out_ready = 1'b1;
    drive(1, 2'b01, 10'($urandom), 8'h5A, 8'h5A);
    tick;
    exp = {1'b1, 1'b0, 4'h6, 8'h00, 1'b1};
    total++; if (got !== exp) $display("FAIL branch got %h exp %h", got, exp); else passed++;
    drive(1, 2'b10, 10'h108, 8'h33, 8'h44);
    tick;
    exp = {1'b1, 1'b1, 4'h0, 8'h00, 1'b1};
    total++; if (got !== exp) $display("FAIL illegal_rtype got %h exp %h", got, exp); else passed++;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1, 2'b00, 10'h000, 8'h10, 8'h20);
    tick;
    exp = {1'b1, 1'b0, 4'h2, 8'h30, 1'b0};
    total++; if (got !== exp) $display("FAIL bp_load got %h exp %h", got, exp); else passed++;
    drive(1, 2'b01, 10'h000, 8'h09, 8'h04);
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (got !== exp || in_ready !== 1'b0) $display("FAIL bp_hold[%0d] got %h rdy %b exp %h rdy 0", i, got, in_ready, exp); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else passed++;
    tick;
    exp = {1'b1, 1'b0, 4'h6, 8'h05, 1'b0};
    total++; if (got !== exp) $display("FAIL bp_next got %h exp %h", got, exp); else passed++;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain out_valid got %b exp 0", out_valid); else passed++;
  endtask
  task automatic test_mul;
    out_ready = 1'b1;
    drive(1, 2'b10, 10'h008, 8'h0D, 8'h0B);
    tick;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
`ifdef ALU_MUL_EN
    for (int i = 0; i < W + 1; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL mul_busy[%0d] rdy %b vld %b exp 0 0", i, in_ready, out_valid); else passed++;
      tick;
    end
    exp = {1'b1, 1'b0, 4'hA, 8'h8F, 1'b0};
`else
    exp = {1'b1, 1'b1, 4'h0, 8'h00, 1'b1};
`endif
    total++; if (got !== exp) $display("FAIL mul_result got %h exp %h", got, exp); else passed++;
    tick;
  endtask
  task automatic test_shift_mask;
    out_ready = 1'b1;
    drive(1, 2'b10, 10'h001, 8'h01, 8'h09);
    tick;
    exp = {1'b1, 1'b0, 4'h4, 8'h02, 1'b0};
    total++; if (got !== exp) $display("FAIL sll_mask got %h exp %h", got, exp); else passed++;
    drive(1, 2'b11, 10'h00D, 8'h80, 8'h01);
    tick;
    exp = {1'b1, 1'b1, 4'h0, 8'h00, 1'b1};
    total++; if (got !== exp) $display("FAIL itype_bad_shift got %h exp %h", got, exp); else passed++;
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    tick;
  endtask
  task automatic test_random;
    logic mv, ei, mi;
    logic [3:0] ec, mc;
    logic [7:0] er, mr, pend;
    logic [6:0] f7;
    int busy;
    mv = 1'b0;
    busy = 0;
    ei = 1'b0;
    ec = '0;
    er = '0;
    pend = '0;
    out_ready = 1'b1;
    tick;
    for (int n = 0; n < 400; n++) begin
      alu_op = 2'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      if (alu_op == 2'b10) funct = $urandom_range(0, 3) == 0 ? 10'($urandom) : legal[$urandom_range(0, 10)];
      else if (alu_op == 2'b11) begin
        f7 = $urandom_range(0, 2) == 0 ? 7'h00 : $urandom_range(0, 1) == 0 ? 7'h20 : 7'($urandom);
        funct = {f7, 3'($urandom)};
      end else funct = 10'($urandom);
      #1;
      total++; if (in_ready !== (busy == 0 && (!mv || out_ready))) $display("FAIL rnd_ready[%0d] got %b", n, in_ready); else passed++;
      @(posedge clk);
      #1;
      if (in_valid && busy == 0 && (!mv || out_ready)) begin
        model(alu_op, funct, a, b, mi, mc, mr);
        if (mc == 4'hA && !mi) begin
          busy = W + 1;
          pend = mr;
          mv = 1'b0;
        end else begin
          mv = 1'b1;
          ei = mi;
          ec = mc;
          er = mr;
        end
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mv = 1'b1;
          ei = 1'b0;
          ec = 4'hA;
          er = pend;
        end
      end else if (out_ready) mv = 1'b0;
      total++; if (out_valid !== mv) $display("FAIL rnd_valid[%0d] got %b exp %b", n, out_valid, mv); else passed++;
      if (mv) begin
        exp = {1'b1, ei, ec, er, er == 8'h00};
        total++; if (got !== exp) $display("FAIL rnd_out[%0d] got %h exp %h", n, got, exp); else passed++;
      end
    end
    drive(0, 2'b00, 10'h000, 8'h00, 8'h00);
    out_ready = 1'b1;
    repeat (W + 3) tick;
  endtask
  initial begin
    test_reset;
    test_rtype_sweep;
    test_branch_illegal;
    test_backpressure;
    test_mul;
    test_shift_mask;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
